// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - shared state encoding, default signature and entry layout for the trace monitor
package riscv_trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  localparam logic [31:0] FAIL_INSTR_DEFAULT = 32'h001e6e13;
  localparam int          TRACE_XLEN         = 32;

  typedef struct packed {
    logic                  err;
    logic [TRACE_XLEN-1:0] instr;
    logic [TRACE_XLEN-1:0] result;
  } trace_entry_t;

endpackage

// File: rtl/riscv_trace_monitor_if.sv
// rtl/riscv_trace_monitor_if.sv - capture strobe and readout handshake between core/host and monitor
interface riscv_trace_monitor_if #(
  parameter int XLEN = 32
);
  logic            cap_valid;
  logic [XLEN-1:0] cap_instr;
  logic [XLEN-1:0] cap_result;
  logic            rd_ready;
  logic            rd_valid;
  logic [XLEN-1:0] rd_instr;
  logic [XLEN-1:0] rd_result;
  logic            rd_err;

  modport master (
    output cap_valid, cap_instr, cap_result, rd_ready,
    input  rd_valid, rd_instr, rd_result, rd_err
  );

  modport slave (
    input  cap_valid, cap_instr, cap_result, rd_ready,
    output rd_valid, rd_instr, rd_result, rd_err
  );
endinterface

// File: rtl/riscv_trace_fifo.sv
// rtl/riscv_trace_fifo.sv - first-word fall-through circular buffer with overwrite-or-drop on full
module riscv_trace_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       drop_on_full,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_pop;
  logic             wr_en;
  logic             overwrite;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop & ~empty;
  // A pop in the same cycle frees a slot, so a full push+pop is never an overflow.
  assign wr_en     = push & (~full | do_pop | ~drop_on_full);
  assign overwrite = push & full & ~do_pop & ~drop_on_full;
  assign ovf       = push & full & ~do_pop;
  assign rdata     = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en)
        wptr <= wptr + AW'(1);
      if (do_pop | overwrite)
        rptr <= rptr + AW'(1);
      count <= count + CW'(wr_en & ~overwrite) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en & ~clr)
      mem[wptr] <= wdata;
  end
endmodule

// File: rtl/riscv_trace_monitor.sv
// rtl/riscv_trace_monitor.sv - retire trace capture with failure-signature trigger and post-trigger freeze
module riscv_trace_monitor
  import riscv_trace_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 16,
  parameter int              POST_TRIG  = 4,
  parameter logic [XLEN-1:0] FAIL_INSTR = XLEN'(FAIL_INSTR_DEFAULT),
  parameter logic [XLEN-1:0] FAIL_MASK  = {XLEN{1'b1}}
) (
  input  logic                       CLK,
  input  logic                       RST,
  riscv_trace_monitor_if.slave       bus,
  input  logic                       mode,
  input  logic                       arm,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                instr_cnt,
  output logic [15:0]                err_cnt,
  output logic                       err_flag,
  output logic                       ovf_flag,
  output logic [1:0]                 state
);
  localparam int PW = $clog2(DEPTH+1);

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] result;
  } entry_t;

  trace_state_t   state_q, state_d;
  logic [PW-1:0]  post_q, post_d;
  logic           capturing;
  logic           match;
  logic           hit;
  entry_t         wentry;
  entry_t         rentry;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_ovf;

  // The arm cycle itself never captures; it only clears and opens the window.
  assign capturing = (state_q == ARMED || state_q == POST) & bus.cap_valid & ~arm;
  assign match     = bus.cap_valid & (((bus.cap_instr ^ FAIL_INSTR) & FAIL_MASK) == '0);
  assign hit       = capturing & match;
  assign wentry    = '{err: match, instr: bus.cap_instr, result: bus.cap_result};

  riscv_trace_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (CLK),
    .rst          (RST),
    .clr          (arm),
    .push         (capturing),
    .pop          (bus.rd_ready),
    .drop_on_full (mode),
    .wdata        (wentry),
    .rdata        (rentry),
    .count        (count),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .ovf          (fifo_ovf)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (arm) begin
      state_d = ARMED;
      post_d  = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (hit) begin
            if (POST_TRIG == 0) begin
              state_d = FROZEN;
            end else begin
              state_d = POST;
              post_d  = PW'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (capturing) begin
            post_d = post_q - PW'(1);
            if (post_q == PW'(1))
              state_d = FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr_cnt <= '0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
    end else if (arm) begin
      instr_cnt <= '0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      if (capturing)
        instr_cnt <= instr_cnt + 32'd1;
      if (hit) begin
        if (err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
        err_flag <= 1'b1;
      end
      if (fifo_ovf)
        ovf_flag <= 1'b1;
    end
  end

  assign bus.rd_valid  = ~fifo_empty;
  assign bus.rd_instr  = rentry.instr;
  assign bus.rd_result = rentry.result;
  assign bus.rd_err    = rentry.err;
  assign state         = state_q;
endmodule

// File: tb/tb_riscv_trace_monitor.sv
// tb/tb_riscv_trace_monitor.sv - scenario tasks plus randomized run against a queue-based reference model
module tb_riscv_trace_monitor;
  import riscv_trace_pkg::*;

  localparam int          DEPTH     = 16;
  localparam int          POST_TRIG = 4;
  localparam logic [31:0] FAIL      = 32'h001e6e13;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mode = 1'b0;
  logic        arm = 1'b0;
  logic [4:0]  count;
  logic [31:0] instr_cnt;
  logic [15:0] err_cnt;
  logic        err_flag;
  logic        ovf_flag;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  riscv_trace_monitor_if #(.XLEN(32)) bus();

  riscv_trace_monitor #(
    .XLEN      (32),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .mode      (mode),
    .arm       (arm),
    .count     (count),
    .instr_cnt (instr_cnt),
    .err_cnt   (err_cnt),
    .err_flag  (err_flag),
    .ovf_flag  (ovf_flag),
    .state     (state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: the buffer is a plain queue, the trigger a countdown of retires.
  trace_entry_t mq[$];
  int           m_state;
  int           m_post;
  logic [31:0]  m_icnt;
  int           m_ecnt;
  bit           m_eflag;
  bit           m_ovf;
  logic [31:0]  ins [24];
  logic [31:0]  res [24];

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_post = 0; m_icnt = 0; m_ecnt = 0; m_eflag = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit a, input bit cv, input logic [31:0] ci, input logic [31:0] cr, input bit rdy);
    bit capt, hit, pop;
    trace_entry_t e;
    if (a) begin
      model_reset();
      m_state = 1;
      return;
    end
    pop  = rdy && (mq.size() > 0);
    capt = cv && (m_state == 1 || m_state == 2);
    hit  = capt && (ci == FAIL);
    if (pop) e = mq.pop_front();
    if (capt) begin
      m_icnt++;
      if (hit) begin
        if (m_ecnt < 65535) m_ecnt++;
        m_eflag = 1;
      end
      e = '{err: hit, instr: ci, result: cr};
      if (mq.size() < DEPTH) mq.push_back(e);
      else begin
        m_ovf = 1;
        if (mode == 1'b0) begin
          void'(mq.pop_front());
          mq.push_back(e);
        end
      end
      if (m_state == 1 && hit) begin
        if (POST_TRIG == 0) m_state = 3;
        else begin m_state = 2; m_post = POST_TRIG; end
      end else if (m_state == 2) begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
  endtask

  task automatic step(input bit a, input bit cv, input logic [31:0] ci, input logic [31:0] cr, input bit rdy);
    @(negedge CLK);
    arm = a; bus.cap_valid = cv; bus.cap_instr = ci; bus.cap_result = cr; bus.rd_ready = rdy;
    model_step(a, cv, ci, cr, rdy);
    @(posedge CLK);
    #1;
    arm = 1'b0; bus.cap_valid = 1'b0; bus.rd_ready = 1'b0;
  endtask

  function automatic logic [31:0] nomatch();
    logic [31:0] v;
    v = $urandom;
    if (v == FAIL) v = v ^ 32'h1;
    return v;
  endfunction

  task automatic fill_stim();
    for (int i = 0; i < 24; i++) begin
      ins[i] = nomatch();
      res[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({bus.rd_valid, bus.rd_err, bus.rd_instr, bus.rd_result} !== 66'd0) begin
      failures++; $display("FAIL reset_rd got=%h exp=0", {bus.rd_valid, bus.rd_err, bus.rd_instr, bus.rd_result}); end
    checks++; if ({instr_cnt, err_cnt, err_flag, ovf_flag} !== 50'd0) begin
      failures++; $display("FAIL reset_stats got=%h exp=0", {instr_cnt, err_cnt, err_flag, ovf_flag}); end
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    mode = 1'b0;
    fill_stim();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, ins[i], res[i], 0);
    checks++; if (count !== 5'd5) begin failures++; $display("FAIL basic_count got=%0d exp=5", count); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.rd_valid, bus.rd_err, bus.rd_instr, bus.rd_result} !== {1'b1, 1'b0, ins[i], res[i]}) begin
        failures++; $display("FAIL basic_pop%0d got=%h exp=%h", i, {bus.rd_valid, bus.rd_err, bus.rd_instr, bus.rd_result}, {1'b1, 1'b0, ins[i], res[i]}); end
      step(0, 0, 0, 0, 1);
    end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL basic_empty got=%b exp=0", bus.rd_valid); end
    checks++; if (instr_cnt !== 32'd5) begin failures++; $display("FAIL basic_instr_cnt got=%0d exp=5", instr_cnt); end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL basic_state got=%0d exp=1", state); end
  endtask

  task automatic test_trigger();
    mode = 1'b0;
    fill_stim();
    ins[2] = FAIL;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      step(0, 1, ins[i], res[i], 0);
      if (i == 5) begin
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL trig_state_r6 got=%0d exp=2", state); end
      end
      if (i == 6) begin
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL trig_state_r7 got=%0d exp=3", state); end
      end
    end
    checks++; if (count !== 5'd7) begin failures++; $display("FAIL trig_count got=%0d exp=7", count); end
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL trig_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (instr_cnt !== 32'd7) begin failures++; $display("FAIL trig_instr_cnt got=%0d exp=7", instr_cnt); end
    for (int i = 0; i < 7; i++) begin
      checks++; if ({bus.rd_err, bus.rd_instr} !== {1'(i == 2), ins[i]}) begin
        failures++; $display("FAIL trig_entry%0d got=%h exp=%h", i, {bus.rd_err, bus.rd_instr}, {1'(i == 2), ins[i]}); end
      step(0, 0, 0, 0, 1);
    end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL trig_frozen_after_pop got=%0d exp=3", state); end
  endtask

  task automatic test_full_modes();
    for (int md = 0; md < 2; md++) begin
      mode = 1'(md);
      fill_stim();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 1, ins[i], res[i], 0);
      checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_m%0d_count got=%0d exp=16", md, count); end
      checks++; if (bus.rd_instr !== ins[md == 0 ? 4 : 0]) begin
        failures++; $display("FAIL full_m%0d_head got=%h exp=%h", md, bus.rd_instr, ins[md == 0 ? 4 : 0]); end
      checks++; if ({instr_cnt, ovf_flag} !== {32'd20, 1'b1}) begin
        failures++; $display("FAIL full_m%0d_cnt_ovf got=%0d/%b exp=20/1", md, instr_cnt, ovf_flag); end
    end
  endtask

  task automatic test_back_to_back();
    mode = 1'b0;
    fill_stim();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, ins[i], res[i], 0);
    for (int i = 0; i < 8; i++) begin
      checks++; if ({bus.rd_instr, bus.rd_result} !== {ins[i], res[i]}) begin
        failures++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, {bus.rd_instr, bus.rd_result}, {ins[i], res[i]}); end
      step(0, 1, ins[16+i], res[16+i], 1);
      checks++; if (count !== 5'd16) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=16", i, count); end
    end
    checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%b exp=0", ovf_flag); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0;
    fill_stim();
    ins[2] = FAIL;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, ins[i], res[i], 0);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL rmid_pre_state got=%0d exp=2", state); end
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    checks++; if ({state, count, err_flag, bus.rd_valid} !== 9'd0) begin
      failures++; $display("FAIL rmid_async got=%h exp=0", {state, count, err_flag, bus.rd_valid}); end
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    step(1, 0, 0, 0, 0);
    for (int i = 4; i < 7; i++) step(0, 1, ins[i], res[i], 0);
    checks++; if ({state, count, instr_cnt} !== {2'd1, 5'd3, 32'd3}) begin
      failures++; $display("FAIL rmid_resume got=%0d/%0d/%0d exp=1/3/3", state, count, instr_cnt); end
    checks++; if (bus.rd_instr !== ins[4]) begin failures++; $display("FAIL rmid_head got=%h exp=%h", bus.rd_instr, ins[4]); end
  endtask

  task automatic test_random();
    logic [65:0] exp_head;
    logic [49:0] exp_stats;
    bit a, cv, rdy;
    logic [31:0] ci;
    for (int n = 0; n < 800; n++) begin
      a = ($urandom_range(39) == 0);
      if (a) mode = 1'($urandom_range(1));
      cv  = ($urandom_range(3) != 0);
      rdy = ($urandom_range(2) == 0);
      ci  = ($urandom_range(7) == 0) ? FAIL : nomatch();
      step(a, cv, ci, $urandom, rdy);
      exp_head  = (mq.size() > 0) ? {1'b1, mq[0].err, mq[0].instr, mq[0].result} : 66'd0;
      exp_stats = {m_icnt, 16'(m_ecnt), m_eflag, m_ovf};
      checks++; if (state !== 2'(m_state)) begin failures++; $display("FAIL rand%0d_state got=%0d exp=%0d", n, state, m_state); end
      checks++; if (count !== 5'(mq.size())) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, count, mq.size()); end
      checks++; if ({bus.rd_valid, bus.rd_err, bus.rd_instr, bus.rd_result} !== exp_head) begin
        failures++; $display("FAIL rand%0d_head got=%h exp=%h", n, {bus.rd_valid, bus.rd_err, bus.rd_instr, bus.rd_result}, exp_head); end
      checks++; if ({instr_cnt, err_cnt, err_flag, ovf_flag} !== exp_stats) begin
        failures++; $display("FAIL rand%0d_stats got=%h exp=%h", n, {instr_cnt, err_cnt, err_flag, ovf_flag}, exp_stats); end
    end
  endtask

  initial begin
    bus.cap_valid = 1'b0; bus.cap_instr = '0; bus.cap_result = '0; bus.rd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    test_reset();
    test_basic();
    test_trigger();
    test_full_modes();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
